// File: rtl/regfile_sb.sv
// regfile_sb: parametrised 2-read/1-write register file with registered read
// ports, optional write-to-read bypass, optional hardwired zero register and a
// per-register busy scoreboard for pending writebacks.
//
// Read handshake: a read is always accepted (there is no ready). rd_valid_x is
// high for exactly the cycle after an edge that sampled rd_en_x=1. rd_data_x
// and rd_busy_x only change on such edges and hold otherwise.
module regfile_sb #(
    parameter int DW       = 16,
    parameter int AW       = 4,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rd_en_a,
    input  logic [AW-1:0] rd_addr_a,
    output logic [DW-1:0] rd_data_a,
    output logic          rd_valid_a,
    output logic          rd_busy_a,
    input  logic          rd_en_b,
    input  logic [AW-1:0] rd_addr_b,
    output logic [DW-1:0] rd_data_b,
    output logic          rd_valid_b,
    output logic          rd_busy_b,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          res_en,
    input  logic [AW-1:0] res_addr,
    output logic [AW:0]   busy_cnt
);

    localparam int DEPTH = 2 ** AW;

    logic [DW-1:0]    mem [DEPTH];
    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] busy_nxt;
    logic [AW:0]      cnt_nxt;
    logic             wr_ok;
    logic             res_ok;
    logic [DW-1:0]    data_a_nxt;
    logic [DW-1:0]    data_b_nxt;
    logic             busy_a_nxt;
    logic             busy_b_nxt;

    // Register 0 is immutable when hardwired to zero.
    assign wr_ok  = wr_en  && !((ZERO_REG != 0) && (wr_addr  == '0));
    assign res_ok = res_en && !((ZERO_REG != 0) && (res_addr == '0));

    // Next busy vector: a writeback clears, a reservation sets and wins a tie.
    always_comb begin
        busy_nxt = busy;
        if (wr_ok) begin
            busy_nxt[wr_addr] = 1'b0;
        end
        if (res_ok) begin
            busy_nxt[res_addr] = 1'b1;
        end
    end

    // Population count of the next busy vector (width AW+1 so 2**AW fits).
    always_comb begin
        cnt_nxt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            cnt_nxt = cnt_nxt + (AW + 1)'(busy_nxt[i]);
        end
    end

    // Port A read source: zero register, forwarded write, or stored value.
    always_comb begin
        data_a_nxt = mem[rd_addr_a];
        busy_a_nxt = busy[rd_addr_a];
        if ((ZERO_REG != 0) && (rd_addr_a == '0)) begin
            data_a_nxt = '0;
            busy_a_nxt = 1'b0;
        end else if ((BYPASS != 0) && wr_ok && (wr_addr == rd_addr_a)) begin
            data_a_nxt = wr_data;
            busy_a_nxt = 1'b0;
        end
    end

    // Port B read source: same selection as port A, fully independent.
    always_comb begin
        data_b_nxt = mem[rd_addr_b];
        busy_b_nxt = busy[rd_addr_b];
        if ((ZERO_REG != 0) && (rd_addr_b == '0)) begin
            data_b_nxt = '0;
            busy_b_nxt = 1'b0;
        end else if ((BYPASS != 0) && wr_ok && (wr_addr == rd_addr_b)) begin
            data_b_nxt = wr_data;
            busy_b_nxt = 1'b0;
        end
    end

    // Storage array; cleared by reset so no X can reach a read port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_ok) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Busy scoreboard and its registered population count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            busy     <= busy_nxt;
            busy_cnt <= cnt_nxt;
        end
    end

    // Port A output register: data/busy captured on a read, valid pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_a  <= '0;
            rd_busy_a  <= 1'b0;
            rd_valid_a <= 1'b0;
        end else begin
            rd_valid_a <= rd_en_a;
            if (rd_en_a) begin
                rd_data_a <= data_a_nxt;
                rd_busy_a <= busy_a_nxt;
            end
        end
    end

    // Port B output register: data/busy captured on a read, valid pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_b  <= '0;
            rd_busy_b  <= 1'b0;
            rd_valid_b <= 1'b0;
        end else begin
            rd_valid_b <= rd_en_b;
            if (rd_en_b) begin
                rd_data_b <= data_b_nxt;
                rd_busy_b <= busy_b_nxt;
            end
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: drives two regfile_sb instances from the same stimulus, one
// with BYPASS=1/ZERO_REG=1 (u_dflt) and one with BYPASS=0/ZERO_REG=0 (u_alt),
// and compares every post-edge output against a behavioural reference.
module tb_regfile_sb;

    localparam int W = 41; // {data_a, valid_a, busy_a, data_b, valid_b, busy_b, busy_cnt}

    // ---------------------------------------------------------------- clock/reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #1 clk = ~clk;

    logic        rd_en_a = 1'b0, rd_en_b = 1'b0, wr_en = 1'b0, res_en = 1'b0;
    logic [3:0]  rd_addr_a = '0, rd_addr_b = '0, wr_addr = '0, res_addr = '0;
    logic [15:0] wr_data = '0;

    logic [15:0] rd_data_a0, rd_data_b0, rd_data_a1, rd_data_b1;
    logic        rd_valid_a0, rd_valid_b0, rd_busy_a0, rd_busy_b0;
    logic        rd_valid_a1, rd_valid_b1, rd_busy_a1, rd_busy_b1;
    logic [4:0]  busy_cnt0, busy_cnt1;

    regfile_sb #(.DW(16), .AW(4), .BYPASS(1), .ZERO_REG(1)) u_dflt (
        .clk(clk), .rst(rst),
        .rd_en_a(rd_en_a), .rd_addr_a(rd_addr_a), .rd_data_a(rd_data_a0),
        .rd_valid_a(rd_valid_a0), .rd_busy_a(rd_busy_a0),
        .rd_en_b(rd_en_b), .rd_addr_b(rd_addr_b), .rd_data_b(rd_data_b0),
        .rd_valid_b(rd_valid_b0), .rd_busy_b(rd_busy_b0),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .res_en(res_en), .res_addr(res_addr), .busy_cnt(busy_cnt0)
    );

    regfile_sb #(.DW(16), .AW(4), .BYPASS(0), .ZERO_REG(0)) u_alt (
        .clk(clk), .rst(rst),
        .rd_en_a(rd_en_a), .rd_addr_a(rd_addr_a), .rd_data_a(rd_data_a1),
        .rd_valid_a(rd_valid_a1), .rd_busy_a(rd_busy_a1),
        .rd_en_b(rd_en_b), .rd_addr_b(rd_addr_b), .rd_data_b(rd_data_b1),
        .rd_valid_b(rd_valid_b1), .rd_busy_b(rd_busy_b1),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .res_en(res_en), .res_addr(res_addr), .busy_cnt(busy_cnt1)
    );

    logic [W-1:0] obs0, obs1;
    logic         all_zero;
    assign obs0 = {rd_data_a0, rd_valid_a0, rd_busy_a0, rd_data_b0, rd_valid_b0, rd_busy_b0, busy_cnt0};
    assign obs1 = {rd_data_a1, rd_valid_a1, rd_busy_a1, rd_data_b1, rd_valid_b1, rd_busy_b1, busy_cnt1};
    assign all_zero = (obs0 == '0) && (obs1 == '0);

    // ---------------------------------------------------------------- checking
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------- reference model
    logic [15:0]  m_mem  [2][16];
    logic         m_busy [2][16];
    logic [W-1:0] m_out  [2];
    logic [W-1:0] exp_q0[$];
    logic [W-1:0] exp_q1[$];

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            for (int i = 0; i < 16; i++) begin
                m_mem[c][i]  = '0;
                m_busy[c][i] = 1'b0;
            end
            m_out[c] = '0;
        end
        exp_q0.delete();
        exp_q1.delete();
    endtask

    task automatic model_read(input int c, input logic bp, input logic zr, input logic [3:0] a,
                              output logic [15:0] d, output logic b);
        if (zr && a == 4'd0) begin
            d = '0;
            b = 1'b0;
        end else if (bp && wr_en && wr_addr == a) begin
            d = wr_data;
            b = 1'b0;
        end else begin
            d = m_mem[c][a];
            b = m_busy[c][a];
        end
    endtask

    // Predict what config c shows after the coming edge, then advance its state.
    task automatic model_edge(input int c);
        logic        bp, zr, va, vb, ba, bb;
        logic [15:0] da, db;
        int          n;
        bp = (c == 0);
        zr = (c == 0);
        da = m_out[c][40:25];
        ba = m_out[c][23];
        db = m_out[c][22:7];
        bb = m_out[c][5];
        va = rd_en_a;
        vb = rd_en_b;
        if (rd_en_a) model_read(c, bp, zr, rd_addr_a, da, ba);
        if (rd_en_b) model_read(c, bp, zr, rd_addr_b, db, bb);
        if (wr_en && !(zr && wr_addr == 4'd0)) begin
            m_mem[c][wr_addr]  = wr_data;
            m_busy[c][wr_addr] = 1'b0;
        end
        if (res_en && !(zr && res_addr == 4'd0)) m_busy[c][res_addr] = 1'b1;
        n = 0;
        for (int i = 0; i < 16; i++) n += int'(m_busy[c][i]);
        m_out[c] = {da, va, ba, db, vb, bb, 5'(n)};
        if (c == 0) exp_q0.push_back(m_out[c]);
        else        exp_q1.push_back(m_out[c]);
    endtask

    task automatic compare(input string who, input logic [W-1:0] got, input logic [W-1:0] exp);
        check({who, ".data_a"},  64'(got[40:25]), 64'(exp[40:25]));
        check({who, ".valid_a"}, 64'(got[24]),    64'(exp[24]));
        check({who, ".busy_a"},  64'(got[23]),    64'(exp[23]));
        check({who, ".data_b"},  64'(got[22:7]),  64'(exp[22:7]));
        check({who, ".valid_b"}, 64'(got[6]),     64'(exp[6]));
        check({who, ".busy_b"},  64'(got[5]),     64'(exp[5]));
        check({who, ".busy_cnt"}, 64'(got[4:0]),  64'(exp[4:0]));
    endtask

    // ---------------------------------------------------------------- driver
    // Inputs change on the falling edge; outputs are sampled on the next one.
    task automatic drive(input logic ea, input logic [3:0] aa, input logic eb, input logic [3:0] ab,
                         input logic we, input logic [3:0] wa, input logic [15:0] wd,
                         input logic re, input logic [3:0] ra);
        rd_en_a = ea; rd_addr_a = aa; rd_en_b = eb; rd_addr_b = ab;
        wr_en = we; wr_addr = wa; wr_data = wd; res_en = re; res_addr = ra;
        model_edge(0);
        model_edge(1);
        @(negedge clk);
        if (exp_q0.size() == 0 || exp_q1.size() == 0) begin
            check("queue_empty", 64'd1, 64'd0);
        end else begin
            compare("dflt", obs0, exp_q0.pop_front());
            compare("alt",  obs1, exp_q1.pop_front());
        end
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 16'h0, 0, 0);
    endtask

    // ---------------------------------------------------------------- test sequence
    time t_rst;

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        check("reset_dflt", 64'(obs0), 64'd0);
        check("reset_alt",  64'(obs1), 64'd0);
        rst = 1'b0;

        // Read after reset returns zero data with valid set.
        drive(1, 3, 1, 9, 0, 0, 16'h0, 0, 0);
        check("p1_valid_a", 64'(rd_valid_a0), 64'd1);

        // Back-to-back writes, two dual reads, then idle with held data.
        drive(0, 0, 0, 0, 1, 1, 16'h0001, 0, 0);
        drive(0, 0, 0, 0, 1, 2, 16'h1401, 0, 0);
        drive(0, 0, 0, 0, 1, 3, 16'h0002, 0, 0);
        drive(0, 0, 0, 0, 1, 4, 16'habcd, 0, 0);
        drive(0, 0, 0, 0, 1, 5, 16'h0aac, 0, 0);
        drive(1, 1, 1, 3, 0, 0, 16'h0, 0, 0);
        check("p2_r3", 64'(rd_data_b0), 64'h0002);
        drive(1, 5, 1, 4, 0, 0, 16'h0, 0, 0);
        idle();
        check("p2_held_a", 64'(rd_data_a0), 64'h0aac);
        check("p2_idle_valid", 64'(rd_valid_b0), 64'd0);

        // Same-edge write and read: forwarded vs pre-write value.
        drive(1, 7, 0, 0, 1, 7, 16'h1111, 0, 0);
        check("p3_bypass", 64'(rd_data_a0), 64'h1111);
        check("p3_nobypass", 64'(rd_data_a1), 64'h0000);
        drive(1, 7, 1, 7, 0, 0, 16'h0, 0, 0);
        check("p3_nobypass_next", 64'(rd_data_a1), 64'h1111);

        // Register 0: hardwired in u_dflt, ordinary in u_alt.
        drive(0, 0, 0, 0, 1, 0, 16'habcd, 1, 0);
        drive(1, 0, 1, 0, 0, 0, 16'h0, 0, 0);
        check("p4_zero_data", 64'(rd_data_a0), 64'h0);
        check("p4_r0_alt", 64'(rd_data_a1), 64'habcd);
        drive(0, 0, 0, 0, 1, 0, 16'h0, 0, 0);

        // Scoreboard: reserve, reserve+write tie, plain write clears.
        drive(0, 0, 0, 0, 0, 0, 16'h0, 1, 6);
        check("p5_cnt1", 64'(busy_cnt0), 64'd1);
        drive(1, 6, 0, 0, 0, 0, 16'h0, 0, 0);
        check("p5_busy_r6", 64'(rd_busy_a0), 64'd1);
        drive(0, 0, 0, 0, 1, 6, 16'h5555, 1, 6);
        drive(1, 6, 1, 6, 0, 0, 16'h0, 0, 0);
        check("p5_tie_data", 64'(rd_data_a0), 64'h5555);
        drive(0, 0, 0, 0, 1, 6, 16'h6666, 0, 0);
        check("p5_cleared", 64'(busy_cnt0), 64'd0);

        // Reserve every register: full count reachable without wrap.
        for (int i = 0; i < 16; i++) drive(1, 4'(i), 0, 0, 0, 0, 16'h0, 1, 4'(i));
        check("p5_full_alt", 64'(busy_cnt1), 64'd16);
        check("p5_full_dflt", 64'(busy_cnt0), 64'd15);
        drive(0, 0, 0, 0, 1, 9, 16'h0909, 1, 2);
        for (int i = 0; i < 16; i++) drive(0, 0, 1, 4'(i), 1, 4'(i), 16'(i * 16'h0111), 0, 0);
        check("p5_drained", 64'(busy_cnt1), 64'd0);

        // Asynchronous reset mid-operation with valid read and busy_cnt=3.
        drive(0, 0, 0, 0, 0, 0, 16'h0, 1, 1);
        drive(0, 0, 0, 0, 0, 0, 16'h0, 1, 2);
        drive(1, 1, 0, 0, 0, 0, 16'h0, 1, 3);
        check("p6_pre_cnt", 64'(busy_cnt0), 64'd3);
        check("p6_pre_valid", 64'(rd_valid_a0), 64'd1);
        t_rst = $time;
        rst = 1'b1;
        fork
            wait (all_zero);
            #1;
        join_any
        disable fork;
        check("p6_async_time", 64'($time - t_rst), 64'd0);
        check("p6_rst_dflt", 64'(obs0), 64'd0);
        check("p6_rst_alt",  64'(obs1), 64'd0);
        model_reset();
        rd_en_a = 1'b0; res_en = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        drive(1, 1, 1, 1, 0, 0, 16'h0, 0, 0);
        check("p6_r1_after", 64'(rd_data_a1), 64'h0);

        // Random traffic checked against the reference model.
        for (int k = 0; k < 400; k++) begin
            drive(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                  1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                  1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 16'($urandom),
                  1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
